// File: rtl/sccb_console_pkg.sv
// Shared types and constants for the SCCB register console.
package sccb_console_pkg;

    localparam logic [1:0] MODE_WRITE = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned BTN_L   = 0;
    localparam int unsigned BTN_R   = 1;
    localparam int unsigned BTN_U   = 2;
    localparam int unsigned BTN_D   = 3;
    localparam int unsigned BTN_C   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitDone,
        StVerifyIssue,
        StVerifyAck,
        StVerifyDone
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ACK_TO  = 3'd1,
        ERR_DONE_TO = 3'd2,
        ERR_REJECT  = 3'd3,
        ERR_VERIFY  = 3'd4
    } err_e;

endpackage

// File: rtl/sccb_reg_console_if.sv
// Command/handshake bus between the register console (master) and the i2c host (slave).
interface sccb_reg_console_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();
    logic              usher;
    logic [7:0]        address;
    logic [ADDR_W-1:0] subaddress;
    logic [DATA_W-1:0] data;
    logic [1:0]        mode;
    logic              busy;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output usher, address, subaddress, data, mode,
        input  busy, rd_data
    );

    modport slave (
        input  usher, address, subaddress, data, mode,
        output busy, rd_data
    );
endinterface

// File: rtl/btn_release_edge.sv
// Release detector: one-cycle event when a button goes from pressed to released.
module btn_release_edge #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic [N-1:0] btn,
    output logic [N-1:0] evt
);
    logic [N-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            hist_q <= '0;
        end else begin
            hist_q <= btn;
        end
    end

    assign evt = hist_q & ~btn;
endmodule

// File: rtl/sccb_reg_console.sv
// Button/switch console that selects an OV7670 register and issues SCCB write/read
// commands to the i2c host, with optional write-verify and handshake timeouts.
module sccb_reg_console
    import sccb_console_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 8,
    parameter int unsigned       DATA_W        = 8,
    parameter logic [7:0]        DEV_ADDR      = 8'h42,
    parameter int unsigned       FINE_STEP     = 1,
    parameter int unsigned       COARSE_STEP   = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR    = '0,
    parameter int unsigned       TIMEOUT_CYC   = 65535,
    parameter int unsigned       VERIFY_WRITES = 0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              dbncd_l_btn,
    input  logic              dbncd_r_btn,
    input  logic              dbncd_u_btn,
    input  logic              dbncd_d_btn,
    input  logic              dbncd_c_btn,
    input  logic              i_rw_sel,
    input  logic [DATA_W-1:0] switches,
    output logic [ADDR_W-1:0] o_sel_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [2:0]        o_err_code,
    output logic              o_console_busy,
    sccb_reg_console_if.master host
);
    localparam int unsigned       TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]     TO_VAL = TW'(TIMEOUT_CYC);
    localparam logic [ADDR_W-1:0] FINE   = ADDR_W'(FINE_STEP);
    localparam logic [ADDR_W-1:0] COARSE = ADDR_W'(COARSE_STEP);

    logic [NUM_BTN-1:0] btn, evt;
    state_e             state_q;
    logic [ADDR_W-1:0]  sel_q, sub_q;
    logic [DATA_W-1:0]  data_q, rd_data_q;
    logic [1:0]         mode_q;
    logic               usher_q, rd_valid_q;
    err_e               err_q;
    logic [TW-1:0]      timer_q;

    assign btn = {dbncd_c_btn, dbncd_d_btn, dbncd_u_btn, dbncd_r_btn, dbncd_l_btn};

    btn_release_edge #(.N(NUM_BTN)) u_edge (
        .clk    (clk),
        .reset_ (reset_),
        .btn    (btn),
        .evt    (evt)
    );

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q    <= StIdle;
            sel_q      <= RESET_ADDR;
            sub_q      <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            mode_q     <= MODE_WRITE;
            usher_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= ERR_NONE;
            timer_q    <= '0;
        end else begin
            usher_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Priority chain: centre wins and masks any simultaneous address edit.
                    if (evt[BTN_C]) begin
                        if (host.busy) begin
                            err_q <= ERR_REJECT;
                        end else begin
                            sub_q   <= sel_q;
                            data_q  <= switches;
                            mode_q  <= i_rw_sel ? MODE_READ : MODE_WRITE;
                            usher_q <= 1'b1;
                            state_q <= StIssue;
                        end
                    end else if (evt[BTN_U]) begin
                        sel_q <= sel_q + COARSE;
                    end else if (evt[BTN_D]) begin
                        sel_q <= sel_q - COARSE;
                    end else if (evt[BTN_R]) begin
                        sel_q <= sel_q + FINE;
                    end else if (evt[BTN_L]) begin
                        sel_q <= sel_q - FINE;
                    end
                end
                StIssue, StVerifyIssue: begin
                    timer_q <= '0;
                    state_q <= (state_q == StIssue) ? StWaitAck : StVerifyAck;
                end
                StWaitAck, StVerifyAck: begin
                    if (host.busy) begin
                        timer_q <= '0;
                        state_q <= (state_q == StWaitAck) ? StWaitDone : StVerifyDone;
                    end else if (timer_q == TO_VAL) begin
                        err_q   <= ERR_ACK_TO;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!host.busy) begin
                        if (mode_q == MODE_READ) begin
                            rd_data_q  <= host.rd_data;
                            rd_valid_q <= 1'b1;
                            err_q      <= ERR_NONE;
                            state_q    <= StIdle;
                        end else if (VERIFY_WRITES != 0) begin
                            // Re-read the same register; data_q keeps the value to compare.
                            mode_q  <= MODE_READ;
                            usher_q <= 1'b1;
                            state_q <= StVerifyIssue;
                        end else begin
                            err_q   <= ERR_NONE;
                            state_q <= StIdle;
                        end
                    end else if (timer_q == TO_VAL) begin
                        err_q   <= ERR_DONE_TO;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StVerifyDone: begin
                    if (!host.busy) begin
                        rd_data_q  <= host.rd_data;
                        rd_valid_q <= 1'b1;
                        err_q      <= (host.rd_data != data_q) ? ERR_VERIFY : ERR_NONE;
                        state_q    <= StIdle;
                    end else if (timer_q == TO_VAL) begin
                        err_q   <= ERR_DONE_TO;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_sel_addr      = sel_q;
    assign o_rd_data       = rd_data_q;
    assign o_rd_valid      = rd_valid_q;
    assign o_err_code      = err_q;
    assign o_console_busy  = (state_q != StIdle);
    assign host.usher      = usher_q;
    assign host.address    = {DEV_ADDR[7:1], mode_q[0]};
    assign host.subaddress = sub_q;
    assign host.data       = data_q;
    assign host.mode       = mode_q;
endmodule

// File: tb/tb_sccb_reg_console.sv
// Scoreboard bench: two consoles (plain and write-verify) with behavioural i2c host models.
module tb_sccb_reg_console;
    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [5:0] btns = '0;  // {c1, c0, d, u, r, l}
    logic       rw = 1'b0;
    logic [7:0] sw = '0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] sel0, sel1, rdd0, rdd1;
    logic       rdv0, rdv1, cbusy0, cbusy1;
    logic [2:0] err0, err1;

    logic       ack_en0 = 1'b1, stuck0 = 1'b0;
    logic [7:0] val0 = '0, val1 = '0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] sub;
        logic [7:0] data;
        logic [1:0] mode;
        int         at;
    } ush_t;

    ush_t       ush_q0[$], ush_q1[$];
    logic [7:0] rd_q0[$], rd_q1[$];
    logic [2:0] err_q0[$], err_q1[$];
    logic       prev0 = 1'b0, prev1 = 1'b0;

    sccb_reg_console_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
    sccb_reg_console_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

    sccb_reg_console #(.TIMEOUT_CYC(20), .VERIFY_WRITES(0)) dut0 (
        .clk(clk), .reset_(reset_),
        .dbncd_l_btn(btns[0]), .dbncd_r_btn(btns[1]), .dbncd_u_btn(btns[2]),
        .dbncd_d_btn(btns[3]), .dbncd_c_btn(btns[4]),
        .i_rw_sel(rw), .switches(sw),
        .o_sel_addr(sel0), .o_rd_data(rdd0), .o_rd_valid(rdv0), .o_err_code(err0),
        .o_console_busy(cbusy0), .host(if0)
    );

    sccb_reg_console #(.TIMEOUT_CYC(20), .VERIFY_WRITES(1)) dut1 (
        .clk(clk), .reset_(reset_),
        .dbncd_l_btn(btns[0]), .dbncd_r_btn(btns[1]), .dbncd_u_btn(btns[2]),
        .dbncd_d_btn(btns[3]), .dbncd_c_btn(btns[5]),
        .i_rw_sel(rw), .switches(sw),
        .o_sel_addr(sel1), .o_rd_data(rdd1), .o_rd_valid(rdv1), .o_err_code(err1),
        .o_console_busy(cbusy1), .host(if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ush_t mk(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                                input logic [1:0] m, input int at);
        ush_t u;
        u.addr = a; u.sub = s; u.data = d; u.mode = m; u.at = at;
        return u;
    endfunction

    // Host models: acknowledge one cycle after the strobe, stay busy 10 cycles.
    initial begin
        if0.busy = 1'b0; if0.rd_data = '0;
        forever begin
            @(negedge clk);
            if (stuck0) begin
                if0.busy = 1'b1;
            end else if (if0.usher && ack_en0) begin
                if0.busy = 1'b1;
                repeat (10) @(negedge clk);
                if0.rd_data = val0;
                if0.busy = 1'b0;
            end else begin
                if0.busy = 1'b0;
            end
        end
    end

    initial begin
        if1.busy = 1'b0; if1.rd_data = '0;
        forever begin
            @(negedge clk);
            if (if1.usher) begin
                if1.busy = 1'b1;
                repeat (10) @(negedge clk);
                if1.rd_data = val1;
                if1.busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        ush_t e;
        if (if0.usher) begin
            chk("usher0 expected", int'(ush_q0.size() != 0), 1);
            if (ush_q0.size() != 0) begin
                e = ush_q0.pop_front();
                chk("usher0 address", if0.address, e.addr);
                chk("usher0 subaddress", if0.subaddress, e.sub);
                chk("usher0 data", if0.data, e.data);
                chk("usher0 mode", if0.mode, e.mode);
                if (e.at >= 0) chk("usher0 cycle", cyc, e.at);
            end
        end
        if (if1.usher) begin
            chk("usher1 expected", int'(ush_q1.size() != 0), 1);
            if (ush_q1.size() != 0) begin
                e = ush_q1.pop_front();
                chk("usher1 address", if1.address, e.addr);
                chk("usher1 subaddress", if1.subaddress, e.sub);
                chk("usher1 data", if1.data, e.data);
                chk("usher1 mode", if1.mode, e.mode);
                if (e.at >= 0) chk("usher1 cycle", cyc, e.at);
            end
        end
        if (rdv0) begin
            chk("rd_valid0 expected", int'(rd_q0.size() != 0), 1);
            if (rd_q0.size() != 0) chk("rd_data0", rdd0, rd_q0.pop_front());
        end
        if (rdv1) begin
            chk("rd_valid1 expected", int'(rd_q1.size() != 0), 1);
            if (rd_q1.size() != 0) chk("rd_data1", rdd1, rd_q1.pop_front());
        end
        if (prev0 && !cbusy0) begin
            chk("done0 expected", int'(err_q0.size() != 0), 1);
            if (err_q0.size() != 0) chk("err_code0", err0, err_q0.pop_front());
        end
        if (prev1 && !cbusy1) begin
            chk("done1 expected", int'(err_q1.size() != 0), 1);
            if (err_q1.size() != 0) chk("err_code1", err1, err_q1.pop_front());
        end
        prev0 <= cbusy0;
        prev1 <= cbusy1;
    end

    task automatic press(input logic [5:0] m, output int rel);
        @(negedge clk);
        btns = m;
        @(negedge clk);
        btns = '0;
        rel = cyc;
    endtask

    task automatic tap(input logic [5:0] m, input int n);
        int rel;
        for (int i = 0; i < n; i++) press(m, rel);
        @(negedge clk);
    endtask

    task automatic wait_idle(input bit which);
        int n = 0;
        repeat (3) @(negedge clk);
        while ((which ? (cbusy1 || if1.busy) : (cbusy0 || if0.busy)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(which ? "idle1 within budget" : "idle0 within budget", int'(n < 300), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int rel;
        repeat (3) @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        chk("reset sel_addr", sel0, 8'h00);
        chk("reset usher", if0.usher, 0);
        chk("reset address", if0.address, 8'h42);
        chk("reset err", err0, 0);
        chk("reset rd_data", rdd0, 0);
        chk("reset busy", cbusy0, 0);

        tap(6'b000010, 3);
        tap(6'b000100, 1);
        chk("addr r3 u1", sel0, 8'h13);
        tap(6'b001000, 1);
        tap(6'b000010, 2);
        chk("addr at 05", sel0, 8'h05);
        tap(6'b001000, 2);
        chk("addr wrap down", sel0, 8'hE5);
        tap(6'b000100, 3);
        tap(6'b000001, 3);
        chk("addr 12", sel0, 8'h12);
        chk("addr 12 dut1", sel1, 8'h12);

        // Plain write
        rw = 1'b0; sw = 8'h80;
        press(6'b010000, rel);
        ush_q0.push_back(mk(8'h42, 8'h12, 8'h80, 2'b00, rel + 1));
        err_q0.push_back(3'd0);
        wait_idle(0);

        // Read back
        tap(6'b000001, 8);
        chk("addr 0A", sel0, 8'h0A);
        rw = 1'b1; val0 = 8'h76;
        press(6'b010000, rel);
        ush_q0.push_back(mk(8'h43, 8'h0A, 8'h80, 2'b01, rel + 1));
        rd_q0.push_back(8'h76);
        err_q0.push_back(3'd0);
        wait_idle(0);

        // Write-verify mismatch, then match
        rw = 1'b0; sw = 8'h55; val1 = 8'h54;
        press(6'b100000, rel);
        ush_q1.push_back(mk(8'h42, 8'h0A, 8'h55, 2'b00, rel + 1));
        ush_q1.push_back(mk(8'h43, 8'h0A, 8'h55, 2'b01, -1));
        rd_q1.push_back(8'h54);
        err_q1.push_back(3'd4);
        wait_idle(1);
        val1 = 8'h55;
        press(6'b100000, rel);
        ush_q1.push_back(mk(8'h42, 8'h0A, 8'h55, 2'b00, rel + 1));
        ush_q1.push_back(mk(8'h43, 8'h0A, 8'h55, 2'b01, -1));
        rd_q1.push_back(8'h55);
        err_q1.push_back(3'd0);
        wait_idle(1);

        // Ack timeout
        ack_en0 = 1'b0; sw = 8'h3C;
        press(6'b010000, rel);
        ush_q0.push_back(mk(8'h42, 8'h0A, 8'h3C, 2'b00, rel + 1));
        err_q0.push_back(3'd1);
        wait_idle(0);
        ack_en0 = 1'b1;

        // Host busy at the press: rejected, no strobe
        stuck0 = 1'b1;
        repeat (2) @(negedge clk);
        press(6'b010000, rel);
        repeat (3) @(negedge clk);
        chk("reject err", err0, 3);
        chk("reject stays idle", cbusy0, 0);
        stuck0 = 1'b0;
        repeat (3) @(negedge clk);

        // Centre and left together: command wins, address edit dropped
        sw = 8'h11;
        press(6'b010001, rel);
        ush_q0.push_back(mk(8'h42, 8'h0A, 8'h11, 2'b00, rel + 1));
        err_q0.push_back(3'd0);
        wait_idle(0);
        chk("c+l addr kept", sel0, 8'h0A);
        chk("l alone dut1", sel1, 8'h09);

        // Reset during WAIT_DONE
        sw = 8'h22;
        press(6'b010000, rel);
        ush_q0.push_back(mk(8'h42, 8'h0A, 8'h22, 2'b00, rel + 1));
        err_q0.push_back(3'd0);
        repeat (5) @(negedge clk);
        chk("mid-command busy", int'(cbusy0 && if0.busy), 1);
        reset_ = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        chk("mid reset idle", cbusy0, 0);
        chk("mid reset usher", if0.usher, 0);
        chk("mid reset sel", sel0, 8'h00);
        chk("mid reset subaddress", if0.subaddress, 8'h00);
        repeat (20) @(negedge clk);
        chk("post reset err", err0, 0);

        chk("usher0 queue drained", ush_q0.size(), 0);
        chk("usher1 queue drained", ush_q1.size(), 0);
        chk("rd0 queue drained", rd_q0.size(), 0);
        chk("rd1 queue drained", rd_q1.size(), 0);
        chk("err0 queue drained", err_q0.size(), 0);
        chk("err1 queue drained", err_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
